// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in sysclk cycles.
// Optional 3-sample glitch filter when `PWM_CAPTURE_FILTER_EN is defined (adds 2 cycles of latency).
`timescale 1ns/1ps
module pwm_capture #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 sysclk,
    input  logic                 i_rst,
    input  logic                 i_enb,
    input  logic                 i_pwm,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic [CNT_WIDTH-1:0] o_high,
    output logic                 o_valid,
    output logic                 o_timeout,
    output logic                 o_level
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

    logic                 sync1_q, sync2_q;
    logic                 lvl_d, lvl_q;
    logic                 rise, fall;
    state_t               state_d, state_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic [CNT_WIDTH-1:0] hcnt_d, hcnt_q;
    logic [CNT_WIDTH-1:0] period_d, period_q;
    logic [CNT_WIDTH-1:0] high_d, high_q;
    logic                 valid_d, valid_q;
    logic                 tout_d, tout_q;

    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_pwm;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    // flt counts consecutive samples disagreeing with the accepted level
    logic [1:0] flt_d, flt_q;

    always_comb begin
        flt_d = 2'd0;
        lvl_d = lvl_q;
        if (sync2_q != lvl_q) begin
            if (flt_q == 2'd2) begin
                lvl_d = sync2_q;
            end else begin
                flt_d = flt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) flt_q <= 2'd0;
        else       flt_q <= flt_d;
    end

    assign o_level = lvl_q;
`else
    assign lvl_d   = sync2_q;
    assign o_level = sync2_q;
`endif

    assign rise = lvl_d & ~lvl_q;
    assign fall = ~lvl_d & lvl_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        tout_d   = tout_q;
        if (!i_enb) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS_HIGH;
                    end
                end
                MEAS_HIGH, MEAS_LOW: begin
                    // saturation wins over any edge so valid never coincides with timeout
                    if (cnt_q == CNT_MAX) begin
                        tout_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (state_q == MEAS_HIGH && fall) begin
                            hcnt_d  = cnt_q;
                            state_d = MEAS_LOW;
                        end
                        if (state_q == MEAS_LOW && rise) begin
                            period_d = cnt_q;
                            high_d   = hcnt_q;
                            valid_d  = 1'b1;
                            tout_d   = 1'b0;
                            cnt_d    = CNT_ONE;
                            state_d  = MEAS_HIGH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
            lvl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            tout_q   <= tout_d;
            lvl_q    <= lvl_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_timeout = tout_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: random and directed PWM streams checked against a segment-level model.
`timescale 1ns/1ps
module tb_pwm_capture;
    localparam int CW   = 16;
    localparam int TMAX = (1 << CW) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT  = 5;
    localparam int MINW = 3;
`else
    localparam int LAT  = 3;
    localparam int MINW = 1;
`endif

    typedef struct packed {
        int cyc;
        int per;
        int hi;
    } ev_t;

    logic          sysclk = 1'b0;
    logic          i_rst  = 1'b0;
    logic          i_enb  = 1'b0;
    logic          i_pwm  = 1'b0;
    logic [CW-1:0] o_period, o_high;
    logic          o_valid, o_timeout, o_level;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    ev_t ev_q[$];
    ev_t exp_q[$];
    int  seg_h[$], seg_l[$], rise_q[$];
    logic tout_prev = 1'b0;
    int   tout_rise_cyc = -1;
    logic tout_rise_vld = 1'b0;

    pwm_capture #(.CNT_WIDTH(CW)) dut (
        .sysclk   (sysclk),
        .i_rst    (i_rst),
        .i_enb    (i_enb),
        .i_pwm    (i_pwm),
        .o_period (o_period),
        .o_high   (o_high),
        .o_valid  (o_valid),
        .o_timeout(o_timeout),
        .o_level  (o_level)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin : mon
        ev_t e;
        if (o_valid) begin
            e.cyc = cyc;
            e.per = int'(o_period);
            e.hi  = int'(o_high);
            ev_q.push_back(e);
        end
        if (o_timeout && !tout_prev) begin
            tout_rise_cyc = cyc;
            tout_rise_vld = o_valid;
        end
        tout_prev = o_timeout;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic clear_q();
        ev_q.delete();
        seg_h.delete();
        seg_l.delete();
        rise_q.delete();
    endtask

    // Pulsing enable puts the block back in its armed-but-idle state.
    task automatic start_stream();
        i_enb = 1'b0;
        tick();
        i_enb = 1'b1;
        clear_q();
    endtask

    task automatic drive_seg(input int h, input int l);
        rise_q.push_back(cyc);
        seg_h.push_back(h);
        seg_l.push_back(l);
        i_pwm = 1'b1;
        repeat (h) tick();
        i_pwm = 1'b0;
        repeat (l) tick();
    endtask

    // Model: first rise arms; every later rise reports the previous segment.
    function automatic void build_exp();
        ev_t e;
        exp_q.delete();
        for (int i = 1; i < seg_h.size(); i++) begin
            e.cyc = rise_q[i] + LAT;
            e.per = seg_h[i-1] + seg_l[i-1];
            e.hi  = seg_h[i-1];
            exp_q.push_back(e);
        end
    endfunction

    function automatic string ev_s(ev_t e);
        return $sformatf("cyc=%0d per=%0d hi=%0d", e.cyc, e.per, e.hi);
    endfunction

    task automatic test_reset();
        i_enb = 1'b1;
        i_pwm = 1'b1;
        #2 i_rst = 1'b1;
        #1;
        checks++; if (o_period !== '0) begin errors++; $display("FAIL rst_period got %0d want 0", o_period); end
        checks++; if (o_high !== '0) begin errors++; $display("FAIL rst_high got %0d want 0", o_high); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b want 0", o_timeout); end
        repeat (4) tick();
        checks++; if (o_level !== 1'b0) begin errors++; $display("FAIL rst_level_held got %b want 0", o_level); end
        i_pwm = 1'b0;
        tick();
        i_rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_basic();
        start_stream();
        repeat (4) drive_seg(64, 192);
        repeat (LAT + 4) tick();
        build_exp();
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
        checks++; if (o_period !== 16'd256 || o_high !== 16'd64) begin errors++; $display("FAIL basic_hold got %0d/%0d want 256/64", o_period, o_high); end
    endtask

    task automatic test_duty_change();
        start_stream();
        repeat (2) drive_seg(64, 192);
        repeat (2) drive_seg(200, 56);
        repeat (LAT + 4) tick();
        build_exp();
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL duty_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL duty_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
    endtask

    task automatic test_random();
        start_stream();
        for (int n = 0; n < 12; n++) drive_seg($urandom_range(60, MINW), $urandom_range(60, MINW));
        repeat (LAT + 4) tick();
        build_exp();
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
    endtask

    task automatic test_min_pulse();
        start_stream();
`ifdef PWM_CAPTURE_FILTER_EN
        repeat (5) drive_seg(1, 9);
        repeat (LAT + 4) tick();
        checks++;
        if (ev_q.size() != 0) begin errors++; $display("FAIL minp_filtered got %0d events want 0", ev_q.size()); end
`else
        repeat (4) drive_seg(1, 9);
        repeat (3) drive_seg(9, 1);
        repeat (LAT + 4) tick();
        build_exp();
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL minp_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL minp_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
`endif
    endtask

    task automatic test_timeout();
        int last_v;
        start_stream();
        repeat (3) drive_seg(100, 100);
        last_v = rise_q[2] + LAT;
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL tout_early got %b want 0", o_timeout); end
        tout_rise_cyc = -1;
`ifdef PWM_CAPTURE_FILTER_EN
        repeat (7000) begin
            i_pwm = 1'b1; tick();
            i_pwm = 1'b0; repeat (9) tick();
        end
`else
        i_pwm = 1'b0;
        repeat (70000) tick();
`endif
        checks++; if (o_timeout !== 1'b1) begin errors++; $display("FAIL tout_flag got %b want 1", o_timeout); end
        checks++; if (tout_rise_cyc != last_v + TMAX) begin errors++; $display("FAIL tout_cycle got %0d want %0d", tout_rise_cyc, last_v + TMAX); end
        checks++; if (tout_rise_vld !== 1'b0) begin errors++; $display("FAIL tout_with_valid got %b want 0", tout_rise_vld); end
        checks++; if (o_level !== 1'b0) begin errors++; $display("FAIL tout_level got %b want 0", o_level); end
        checks++; if (o_period !== 16'd200 || o_high !== 16'd100) begin errors++; $display("FAIL tout_retain got %0d/%0d want 200/100", o_period, o_high); end
        checks++; if (ev_q.size() != 2) begin errors++; $display("FAIL tout_events got %0d want 2", ev_q.size()); end
        clear_q();
        repeat (2) drive_seg(50, 50);
        repeat (LAT + 4) tick();
        build_exp();
        checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL tout_clear got %b want 0", o_timeout); end
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL tout_rec_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL tout_rec_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
    endtask

    task automatic test_reset_mid();
        start_stream();
        repeat (2) drive_seg(80, 80);
        i_pwm = 1'b1;
        repeat (30) tick();
        checks++; if (o_period !== 16'd160 || o_level !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0d lvl %b want 160 lvl 1", o_period, o_level); end
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_period !== '0 || o_high !== '0 || o_valid !== 1'b0 || o_timeout !== 1'b0 || o_level !== 1'b0) begin
            errors++;
            $display("FAIL rmid_zero got per %0d hi %0d v %b t %b l %b want all 0", o_period, o_high, o_valid, o_timeout, o_level);
        end
        i_pwm = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        clear_q();
        repeat (3) drive_seg(40, 60);
        repeat (LAT + 4) tick();
        build_exp();
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
    endtask

    task automatic test_enable();
        start_stream();
        repeat (3) drive_seg(30, 50);
        repeat (LAT + 4) tick();
        i_enb = 1'b0;
        clear_q();
        repeat (2) drive_seg(20, 30);
        checks++; if (ev_q.size() != 0) begin errors++; $display("FAIL enb_off_events got %0d want 0", ev_q.size()); end
        checks++; if (o_period !== 16'd80 || o_high !== 16'd30) begin errors++; $display("FAIL enb_off_hold got %0d/%0d want 80/30", o_period, o_high); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL enb_off_valid got %b want 0", o_valid); end
        i_enb = 1'b1;
        clear_q();
        repeat (3) drive_seg(25, 35);
        repeat (LAT + 4) tick();
        build_exp();
        checks++;
        if (ev_q.size() != exp_q.size()) begin errors++; $display("FAIL enb_on_count got %0d want %0d", ev_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < ev_q.size()) begin
            checks++;
            if (ev_q[i] !== exp_q[i]) begin errors++; $display("FAIL enb_on_ev%0d got %s want %s", i, ev_s(ev_q[i]), ev_s(exp_q[i])); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_change();
        test_random();
        test_min_pulse();
        test_timeout();
        test_reset_mid();
        test_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
